// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: sequences single-port RAM control pins for a valid/ready request stream, with zero-fill sweep.
module ram_seq_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_req,
  output logic          init_busy,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_re,
  output logic          ram_oe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  // RST is the one-cycle hold-off after reset so the sweep starts cleanly at address 0
  typedef enum logic [2:0] {RST, CLR, IDLE, WR, RD1, RD2, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d, init_busy_q, init_busy_d;
  logic cs_q, cs_d, we_q, we_d, re_q, re_d, oe_q, oe_d;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      RST: state_d = INIT_ON_RESET ? CLR : IDLE;
      CLR: begin
        state_d = &addr_q ? IDLE : CLR;
        addr_d = &addr_q ? addr_q : addr_q + 1'b1;
      end
      IDLE:
        if (clr_req) begin
          state_d = CLR;
          addr_d = '0;
          wdata_d = '0;
        end else if (req_valid && req_ready_q) begin
          state_d = req_we ? WR : RD1;
          addr_d = req_addr;
          wdata_d = req_we ? req_wdata : wdata_q;
        end
      WR: state_d = IDLE;
      RD1: state_d = RD2;
      RD2: begin
        state_d = RESP;
        rdata_d = ram_rdata;
        rsp_valid_d = 1'b1;
      end
      RESP:
        if (rsp_ready) begin
          state_d = IDLE;
          rsp_valid_d = 1'b0;
        end
      default: state_d = RST;
    endcase
    // pins are registered from the next state so they line up with the state they belong to
    cs_d = state_d inside {CLR, WR, RD1, RD2};
    we_d = state_d inside {CLR, WR};
    re_d = state_d inside {RD1, RD2};
    oe_d = state_d == RD2;
    req_ready_d = state_d == IDLE;
    init_busy_d = state_d == CLR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      init_busy_q <= 1'b0;
      cs_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      init_busy_q <= init_busy_d;
      cs_q <= cs_d;
      we_q <= we_d;
      re_q <= re_d;
      oe_q <= oe_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign init_busy = init_busy_q;
  assign ram_cs = cs_q;
  assign ram_we = we_q;
  assign ram_re = re_q;
  assign ram_oe = oe_q;
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed plus random checks of ram_seq_ctrl against a 32x8 RAM model and a reference memory.
module tb_ram_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1, clr_req = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, init_busy, ram_cs, ram_we, ram_re, ram_oe;
  logic [7:0] rsp_rdata, ram_wdata, ram_rdata;
  logic [4:0] ram_addr;
  int n_cmp = 0, n_err = 0;
  logic [7:0] ref_mem [32];
  logic [7:0] mem [32];
  logic [7:0] rd_reg;

  ram_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .clr_req(clr_req), .init_busy(init_busy), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_re(ram_re), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM with a registered read and a 8'h01 idle output
  initial for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  always @(posedge clk) begin
    if (ram_cs && ram_we && !ram_re) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_re && !ram_we) rd_reg <= mem[ram_addr];
  end
  assign ram_rdata = (ram_cs && ram_oe && ram_re) ? rd_reg : 8'h01;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) chk("we_re_exclusive", {ram_we, ram_re}, {ram_we, 1'b0} & {1'b1, ~ram_we & ram_re} | {1'b0, ~ram_we & ram_re});

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_rdata, init_busy, ram_cs, ram_we, ram_re, ram_oe, ram_addr, ram_wdata}, 64'h0);
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      clr_req = 1'b0;
      chk("sweep_pins", {init_busy, ram_cs, ram_we, ram_re, ram_oe, req_ready, rsp_valid}, 7'b1110000);
      chk("sweep_addr", ram_addr, i);
      chk("sweep_wdata", ram_wdata, 0);
    end
    @(negedge clk);
    chk("sweep_done", {init_busy, req_ready, ram_cs}, 3'b010);
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    clr_req = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_outputs");
    rst = 1'b0;
    sweep_check();
  endtask

  // returns at the negedge just after the accepting edge
  task automatic send(input logic we, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    send(1'b1, a, d);
    chk("wr_pins", {ram_cs, ram_we, ram_re, ram_oe, req_ready}, 5'b11000);
    chk("wr_addr_data", {ram_addr, ram_wdata}, {a, d});
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_ready_again", {req_ready, ram_cs, rsp_valid}, 3'b100);
  endtask

  task automatic do_read(input logic [4:0] a, input int hold);
    logic [7:0] exp = ref_mem[a];
    rsp_ready = (hold == 0);
    send(1'b0, a, 8'h00);
    chk("rd1_pins", {ram_cs, ram_we, ram_re, ram_oe, rsp_valid}, 5'b10100);
    chk("rd1_addr", ram_addr, a);
    @(negedge clk);
    chk("rd2_pins", {ram_cs, ram_we, ram_re, ram_oe, rsp_valid}, 5'b10110);
    @(negedge clk);
    chk("rsp_latency", {rsp_valid, req_ready, ram_cs}, 3'b100);
    chk("rsp_data", rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, req_ready, ram_cs, rsp_rdata}, {3'b100, exp});
      if (i == hold - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rsp_cleared", {rsp_valid, req_ready}, 2'b01);
    rsp_ready = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_read(5'd0, 0);
    do_read(5'd17, 0);
    do_read(5'd31, 0);
    do_write(5'd5, 8'hA5);
    do_read(5'd5, 0);
    do_read(5'd5, 10);
    do_write(5'd31, 8'hFF);
    do_write(5'd0, 8'h01);
    do_read(5'd31, 0);
    do_read(5'd0, 0);
    // clear request wins over a simultaneous read; the read is served after the sweep
    do_write(5'd5, 8'h3C);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 5'd5;
    clr_req = 1'b1;
    sweep_check();
    do_read(5'd5, 0);
    // reset landing in RD2 discards the read
    do_write(5'd9, 8'h5A);
    send(1'b0, 5'd9, 8'h00);
    @(negedge clk);
    chk("pre_abort_rd2", {ram_re, ram_oe}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort_rd2");
    do_reset();
    do_read(5'd9, 0);
    for (int k = 0; k < 60; k++) begin
      logic [4:0] a = 5'($urandom);
      if ($urandom_range(1, 0) == 1) do_write(a, 8'($urandom));
      else do_read(a, $urandom_range(3, 0));
    end
    for (int i = 0; i < 32; i++) do_read(5'(i), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Request/response sequencer that sits directly upstream of the 32x8 single-port RAM and owns all of its control pins. It turns a valid/ready request stream into correctly timed chip-select, write-enable, read-enable and output-enable pulses, and captures read data into a response register. It also runs a zero-fill sweep after reset or on demand. RAM semantics: write when cs&we&!re; read data registers when cs&re&!we; data_out is valid only while cs&oe&re, else 8'h01.

## Interface

- AW, 5, RAM address width; depth is 2**AW.
- DW, 8, data width.
- INIT_ON_RESET, 1, 1 = run the zero-fill sweep automatically when reset deasserts.

- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data held on rsp_rdata.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DW  captured read data.
- clr_req  in  1  single-cycle pulse: start zero-fill; honoured only in IDLE.
- init_busy  out  1  zero-fill sweep in progress.
- ram_cs, ram_we, ram_re, ram_oe  out  1 each  RAM control pins.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM data_out.

## Operation

- All outputs are registered. Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, init_busy 0, ram_cs/we/re/oe 0, ram_addr 0, ram_wdata 0.
- FSM states: CLR, IDLE, WR, RD1, RD2, RESP.
- Reset exit: go to CLR if INIT_ON_RESET=1, otherwise to IDLE.
- CLR: drive cs=1, we=1, re=0 and wdata=0. ram_addr steps 0..2**AW-1, one address per cycle. init_busy=1 and req_ready=0 throughout. After the last address, go to IDLE.
- IDLE: req_ready=1. All RAM pins are 0 except that ram_addr and ram_wdata hold their last values.
  - clr_req has priority over req_valid in the same cycle. With clr_req, go to CLR; the request stays pending and is not accepted.
  - If a request is accepted (req_valid & req_ready) with req_we=1, latch addr/wdata and go to WR.
  - If a request is accepted with req_we=0, latch addr and go to RD1.
- WR: one cycle with cs=1, we=1, re=0, oe=0. No response is generated. Return to IDLE.
- RD1: cs=1, re=1, we=0, oe=0. The RAM registers memory[addr] at the end of this cycle.
- RD2: cs=1, re=1, oe=1, we=0, same addr. Capture ram_rdata into rsp_rdata at the end of this cycle. Set rsp_valid=1 and go to RESP.
- RESP: all RAM pins are 0. rsp_valid and rsp_rdata are held stable until rsp_valid & rsp_ready. On that edge rsp_valid drops to 0 and the FSM returns to IDLE. req_ready=0 in RESP.
- Only one transaction is in flight at a time, so req_* are don't-care except in IDLE.
- we and re are never asserted together, in any state.
- clr_req outside IDLE is ignored; it is not queued.
- rst in any state (including mid-CLR, RD1/RD2, or RESP with an undelivered response) aborts the operation and returns all outputs to their reset values. Any pending response is discarded.

## Timing

- Request accepted at edge E0:
  - Write: the RAM writes at edge E1. req_ready is high again in the cycle after E1, so back-to-back writes run at one every 2 cycles.
  - Read: RD1 occupies cycle E0–E1 and RD2 occupies E1–E2. rsp_valid is high starting the cycle after E2, giving 3-cycle request-to-response latency.
  - With rsp_ready held high, req_ready returns after E3, so back-to-back reads run at one every 4 cycles.
- Zero-fill takes exactly 2**AW cycles (32 by default) with init_busy high. req_ready rises in the first cycle after the sweep.
- With INIT_ON_RESET=1, req_ready first goes high 33 cycles after the first edge with rst low.
- ram_addr wraps only through CLR termination; there is no modular increment outside CLR.

## Test plan

- Reset with INIT_ON_RESET=1: init_busy high for 32 cycles with ram_addr 0..31 and we=1. Afterwards, reading addresses 0, 17 and 31 each returns 8'h00.
- Write 8'hA5 to address 5, then read address 5: rsp_rdata=8'hA5 with rsp_valid high 3 cycles after read acceptance. Check we and re are never both 1.
- Back-pressure: read address 5 with rsp_ready low for 10 cycles. rsp_valid and rsp_rdata stay stable, req_ready stays 0, and the response clears on the first cycle with rsp_ready=1.
- Boundaries: write 8'hFF to address 31 and 8'h01 to address 0, then read both back. Expect 8'hFF and 8'h01, with no aliasing between the two addresses.
- Simultaneous clr_req and req_valid in IDLE: the sweep runs first, and the read request (addr 5, previously written 8'h3C) is accepted after the sweep and returns 8'h00.
- rst asserted during RD2: the next cycle has all outputs at reset values and no rsp_valid pulse. After re-init, normal operation resumes.
